// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: FSM state type and statistics counter width shared by the FIFO push arbiter.
package fifo_arb_pkg;
  localparam int STAT_W = 16;
  typedef enum logic [1:0] {IDLE, ARB, LOCKED} state_t;
endpackage

// File: rtl/fifo_push_arb_rr_picker.sv
// rr_picker: one-hot round-robin pick of the first requester after ptr; ports req/ptr in, pick/idx out.
module rr_picker #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx
);
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int k = N; k >= 1; k--)
      if (req[(int'(ptr) + k) % N]) begin
        pick = N'(1) << ((int'(ptr) + k) % N);
        idx  = PW'((int'(ptr) + k) % N);
      end
  end
endmodule

// File: rtl/fifo_push_arb.sv
// fifo_push_arb: credit-tracked round-robin push arbiter with packet lock (clk/rst, req/lock/data_in -> gnt, fifo_push/fifo_din; FIFO status in; optional stat_cnt under FIFO_ARB_STATS_EN).
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int width = 16,
  parameter int depth = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         lock,
  input  logic [N*width-1:0]   data_in,
  output logic [N-1:0]         gnt,
  output logic                 fifo_push,
  output logic [width-1:0]     fifo_din,
  input  logic                 fifo_full,
  input  logic                 fifo_pndng,
  input  logic                 fifo_pop
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [N*STAT_W-1:0]  stat_cnt
`endif
);
  localparam int PW = $clog2(N);
  localparam int OW = $clog2(depth + 1);
  state_t        r_state;
  logic [PW-1:0] r_rr_ptr, r_owner, w_pick_idx, w_idx;
  logic [OW-1:0] r_occ;
  logic [N-1:0]  w_pick;
  logic          w_en, w_acc, w_pop;
  rr_picker #(.N(N), .PW(PW)) u_pick (.req(req), .ptr(r_rr_ptr), .pick(w_pick), .idx(w_pick_idx));
  // credits come from registered occ, so a pop at occ==depth only frees a slot next cycle
  assign w_en  = (r_occ < OW'(depth)) && !fifo_full;
  assign gnt   = !w_en ? '0 : r_state == ARB ? w_pick :
                 r_state == LOCKED ? (req & (N'(1) << r_owner)) : '0;
  assign w_acc = |gnt;
  assign w_idx = r_state == LOCKED ? r_owner : w_pick_idx;
  assign w_pop = fifo_pop && fifo_pndng && r_occ != '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= PW'(N - 1);
      r_owner   <= '0;
      r_occ     <= '0;
      fifo_push <= 1'b0;
      fifo_din  <= '0;
    end else begin
      fifo_push <= w_acc;
      if (w_acc) fifo_din <= data_in[w_idx*width +: width];
      r_occ <= r_occ + OW'(w_acc) - OW'(w_pop);
      case (r_state)
        IDLE: if (|req) r_state <= ARB;
        ARB:
          if (!(|req)) r_state <= IDLE;
          else if (w_acc) begin
            r_rr_ptr <= w_pick_idx;
            if (lock[w_pick_idx]) begin
              r_state <= LOCKED;
              r_owner <= w_pick_idx;
            end
          end
        LOCKED:
          if ((w_acc && !lock[r_owner]) || (!req[r_owner] && !lock[r_owner])) begin
            r_state  <= ARB;
            r_rr_ptr <= r_owner;
          end
        default: r_state <= IDLE;
      endcase
    end
`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat [N];
  for (genvar g = 0; g < N; g++) begin : g_stat
    always_ff @(posedge clk or posedge rst)
      if (rst) r_stat[g] <= '0;
      else if (gnt[g] && r_stat[g] != '1) r_stat[g] <= r_stat[g] + 1'b1;
    assign stat_cnt[g*STAT_W +: STAT_W] = r_stat[g];
  end
`endif
endmodule

// File: tb/tb_fifo_push_arb.sv
// tb_fifo_push_arb: directed and randomized checks of fifo_push_arb against a behavioural model.
module tb_fifo_push_arb;
  logic        clk = 1'b0, rst = 1'b0;
  logic [3:0]  req = '0, lock = '0, gnt;
  logic [63:0] data_in = '0;
  logic        fifo_push, fifo_full = 1'b0, fifo_pndng = 1'b0, fifo_pop = 1'b0;
  logic [15:0] fifo_din;
  int          n_cmp = 0, n_bad = 0;
  int          m_occ, m_rr, m_own;
  bit          m_awake, m_push;
  logic [15:0] m_din;
  logic [3:0]  g;
  int          cnt;
  fifo_push_arb #(.N(4), .width(16), .depth(8)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .data_in(data_in), .gnt(gnt),
    .fifo_push(fifo_push), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .fifo_pndng(fifo_pndng), .fifo_pop(fifo_pop)
  );
  always #5 clk = ~clk;
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [3:0] exp_gnt(input logic [3:0] rq, input logic full);
    if (!m_awake || m_occ >= 8 || full) return 4'b0;
    if (m_own >= 0) return rq[m_own] ? 4'(1 << m_own) : 4'b0;
    for (int k = 1; k <= 4; k++)
      if (rq[(m_rr + k) % 4]) return 4'(1 << ((m_rr + k) % 4));
    return 4'b0;
  endfunction
  task automatic model_reset();
    m_occ = 0; m_rr = 3; m_own = -1; m_awake = 0; m_push = 0; m_din = '0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    #1;
    cmp("rst_push", 32'(fifo_push), 0);
    cmp("rst_din", 32'(fifo_din), 0);
    cmp("rst_gnt", 32'(gnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask
  // one cycle: drive inputs, compare at negedge, advance the model at posedge
  task automatic step(input logic [3:0] rq, input logic [3:0] lk, input logic full,
                      input logic pop, output logic [3:0] gd);
    logic [3:0] eg;
    int w;
    req = rq; lock = lk; fifo_full = full; fifo_pop = pop; fifo_pndng = (m_occ > 0);
    @(negedge clk);
    eg = exp_gnt(rq, full);
    cmp("gnt", 32'(gnt), 32'(eg));
    cmp("push", 32'(fifo_push), 32'(m_push));
    cmp("din", 32'(fifo_din), 32'(m_din));
    gd = gnt;
    @(posedge clk);
    w = 0;
    for (int i = 0; i < 4; i++) if (eg[i]) w = i;
    m_push = eg != 0;
    if (m_push) m_din = data_in[w*16 +: 16];
    m_occ += int'(m_push) - int'(pop && m_occ > 0);
    if (!m_awake) m_awake = |rq;
    else if (m_own >= 0) begin
      if ((m_push && !lk[m_own]) || (!rq[m_own] && !lk[m_own])) begin
        m_rr = m_own; m_own = -1;
      end
    end else if (!(|rq)) m_awake = 0;
    else if (m_push) begin
      m_rr = w;
      if (lk[w]) m_own = w;
    end
    #1;
  endtask
  initial begin
    model_reset();
    for (int i = 0; i < 4; i++) data_in[i*16 +: 16] = 16'hA000 + 16'(i);
    do_reset();
    step(4'b1111, 4'b0, 0, 0, g); cmp("idle_gnt", 32'(g), 0);
    step(4'b1111, 4'b0, 0, 0, g); cmp("rr0", 32'(g), 32'b0001);
    cmp("din0", 32'(fifo_din), 32'hA000);
    step(4'b1111, 4'b0, 0, 0, g); cmp("rr1", 32'(g), 32'b0010);
    cmp("din1", 32'(fifo_din), 32'hA001);
    step(4'b1111, 4'b0, 0, 0, g); cmp("rr2", 32'(g), 32'b0100);
    step(4'b1111, 4'b0, 0, 0, g); cmp("rr3", 32'(g), 32'b1000);
    cmp("din3_pending", 32'(fifo_din), 32'hA003);
    step(4'b1111, 4'b0, 0, 0, g); cmp("rr0b", 32'(g), 32'b0001);
    do_reset();
    step(4'b0100, 4'b0100, 0, 0, g);
    step(4'b0100, 4'b0100, 0, 0, g); cmp("lock_w1", 32'(g), 32'b0100);
    step(4'b0111, 4'b0100, 0, 0, g); cmp("lock_w2", 32'(g), 32'b0100);
    step(4'b0111, 4'b0000, 0, 0, g); cmp("lock_w3", 32'(g), 32'b0100);
    step(4'b1011, 4'b0000, 0, 0, g); cmp("after_lock", 32'(g), 32'b1000);
    do_reset();
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step(4'b0001, 4'b0, 0, 0, g);
      cnt += int'(g != 0);
    end
    cmp("credit_pushes", 32'(cnt), 8);
    cmp("credit_stall_gnt", 32'(gnt), 0);
    cnt = 0;
    step(4'b0001, 4'b0, 0, 1, g);
    cmp("pop_same_cycle_gnt", 32'(g), 0);
    for (int i = 0; i < 4; i++) begin
      step(4'b0001, 4'b0, 0, 0, g);
      cnt += int'(g != 0);
    end
    cmp("one_more_grant", 32'(cnt), 1);
    do_reset();
    step(4'b1111, 4'b0, 1, 0, g);
    step(4'b1111, 4'b0, 1, 0, g); cmp("full_gnt", 32'(g), 0);
    step(4'b1111, 4'b0, 1, 0, g); cmp("full_push", 32'(fifo_push), 0);
    do_reset();
    step(4'b0010, 4'b0010, 0, 0, g);
    step(4'b0010, 4'b0010, 0, 0, g);
    step(4'b0010, 4'b0010, 0, 0, g); cmp("locked_gnt", 32'(g), 32'b0010);
    cmp("push_pending", 32'(fifo_push), 1);
    do_reset();
    step(4'b1111, 4'b0, 0, 0, g); cmp("post_rst_idle", 32'(g), 0);
    step(4'b1111, 4'b0, 0, 0, g); cmp("post_rst_first", 32'(g), 32'b0001);
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      data_in = {$urandom, $urandom};
      step(4'($urandom), 4'($urandom & $urandom), ($urandom % 10) == 0,
           ($urandom % 3) == 0, g);
      if (($urandom % 500) == 0) do_reset();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
